// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: PS/2 keyboard front end for the whack-a-mole game.
// Deframes 11-bit PS/2 frames, follows make/break sequences, maps four game
// keys to a 2-bit hole index and suppresses typematic repeats.
// Optional feature macro: PS2_EXTENDED_EN adds E0-prefixed arrow keys
// (E0 6B/75/72/74 -> holes 0..3) that share the held-key mask with the letters.
// Handshake: codeValid, ifPressed and frameErr are single-cycle strobes with no
// back-pressure; rawCode/keyPressed are valid whenever their strobe is high
// and hold their value until the next accepted update.
// o_dbg_state exposes the deframer state (0 IDLE, 1 DATA, 2 PARITY, 3 STOP).
module ps2_key_receiver #(
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] KEY0_CODE      = 8'h1C,
    parameter logic [7:0] KEY1_CODE      = 8'h1B,
    parameter logic [7:0] KEY2_CODE      = 8'h23,
    parameter logic [7:0] KEY3_CODE      = 8'h2B
) (
    input  logic       systemClock,
    input  logic       reset,
    input  logic       ps2clock,
    input  logic       ps2data,
    output logic [1:0] keyPressed,
    output logic       ifPressed,
    output logic [7:0] rawCode,
    output logic       codeValid,
    output logic       frameErr,
    output logic [1:0] o_dbg_state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam int         TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          r_clk_s1, r_clk_s2, r_clk_prev;
    logic          r_dat_s1, r_dat_s2;
    logic [1:0]    r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [TW-1:0] r_tmo;
    logic [3:0]    r_held;
    logic          r_break_pending;
`ifdef PS2_EXTENDED_EN
    logic          r_ext_pending;
`endif

    logic          w_fall;
    logic          w_timeout;
    logic          w_stop_ok;
    logic          w_accept;
    logic          w_reject;
    logic          w_key_hit;
    logic [1:0]    w_key_idx;

    assign o_dbg_state = r_state;

    // Two-flop synchronisers plus a delayed copy of the clock for edge detection.
    always_ff @(posedge systemClock or negedge reset) begin
        if (!reset) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2clock;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_s2;
    // A falling edge in the same cycle as the last count still belongs to the frame.
    assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_tmo == TMO_LAST);
    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    assign w_stop_ok = r_dat_s2 & (^{r_shift, r_parity});
    assign w_accept  = (r_state == ST_STOP) && w_fall && w_stop_ok;
    assign w_reject  = (r_state == ST_STOP) && w_fall && !w_stop_ok;

    // Deframer FSM: start bit, 8 data bits LSB-first, parity, stop, with inter-edge timeout.
    always_ff @(posedge systemClock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_parity  <= 1'b0;
            r_tmo     <= '0;
            frameErr  <= 1'b0;
        end else begin
            frameErr <= w_reject | w_timeout;
            if (r_state == ST_IDLE) begin
                r_tmo <= '0;
            end else if (w_fall || w_timeout) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TW'(1);
            end

            if (w_timeout) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= 3'd0;
            end else if (w_fall) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        r_shift <= {r_dat_s2, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_state   <= ST_PARITY;
                            r_bit_cnt <= 3'd0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        r_parity <= r_dat_s2;
                        r_state  <= ST_STOP;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Map the freshly received byte to a hole index; arrows only right after E0.
    always_comb begin
        w_key_hit = 1'b0;
        w_key_idx = 2'd0;
`ifdef PS2_EXTENDED_EN
        if (r_ext_pending) begin
            case (r_shift)
                8'h6B:   begin w_key_hit = 1'b1; w_key_idx = 2'd0; end
                8'h75:   begin w_key_hit = 1'b1; w_key_idx = 2'd1; end
                8'h72:   begin w_key_hit = 1'b1; w_key_idx = 2'd2; end
                8'h74:   begin w_key_hit = 1'b1; w_key_idx = 2'd3; end
                default: begin w_key_hit = 1'b0; w_key_idx = 2'd0; end
            endcase
        end else
`endif
        begin
            if (r_shift == KEY0_CODE) begin
                w_key_hit = 1'b1;
                w_key_idx = 2'd0;
            end else if (r_shift == KEY1_CODE) begin
                w_key_hit = 1'b1;
                w_key_idx = 2'd1;
            end else if (r_shift == KEY2_CODE) begin
                w_key_hit = 1'b1;
                w_key_idx = 2'd2;
            end else if (r_shift == KEY3_CODE) begin
                w_key_hit = 1'b1;
                w_key_idx = 2'd3;
            end
        end
    end

    // Make/break tracking and output strobes, updated only by accepted bytes.
    always_ff @(posedge systemClock or negedge reset) begin
        if (!reset) begin
            keyPressed      <= 2'd0;
            ifPressed       <= 1'b0;
            rawCode         <= 8'd0;
            codeValid       <= 1'b0;
            r_held          <= 4'b0;
            r_break_pending <= 1'b0;
`ifdef PS2_EXTENDED_EN
            r_ext_pending   <= 1'b0;
`endif
        end else begin
            codeValid <= 1'b0;
            ifPressed <= 1'b0;
            if (w_accept) begin
                rawCode   <= r_shift;
                codeValid <= 1'b1;
                if (r_shift == 8'hF0) begin
                    r_break_pending <= 1'b1;
                end else if (r_break_pending) begin
                    r_break_pending <= 1'b0;
                    if (w_key_hit) begin
                        r_held[w_key_idx] <= 1'b0;
                    end
`ifdef PS2_EXTENDED_EN
                    r_ext_pending <= 1'b0;
                end else if (r_shift == 8'hE0) begin
                    r_ext_pending <= 1'b1;
`endif
                end else begin
`ifdef PS2_EXTENDED_EN
                    r_ext_pending <= 1'b0;
`endif
                    // A held key repeating (typematic) must not count as a new hit.
                    if (w_key_hit && !r_held[w_key_idx]) begin
                        keyPressed        <= w_key_idx;
                        ifPressed         <= 1'b1;
                        r_held[w_key_idx] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Bench for ps2_key_receiver: directed scenarios followed by random frames,
// scored against a key-tracking model; a monitor consumes expected events.
module tb_ps2_key_receiver;

    localparam int TMO = 1000;

    typedef struct {
        logic [7:0] code;
        logic [1:0] key;
        logic       fire;
    } exp_t;

    logic       systemClock;
    logic       reset;
    logic       ps2clock;
    logic       ps2data;
    logic [1:0] keyPressed;
    logic       ifPressed;
    logic [7:0] rawCode;
    logic       codeValid;
    logic       frameErr;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t exp_q[$];
    exp_t err_q[$];

    // model state
    logic [3:0] m_held;
    logic       m_brk;
    logic       m_ext;
    logic [1:0] m_key;
    logic [7:0] m_raw;

    ps2_key_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
        .systemClock (systemClock),
        .reset       (reset),
        .ps2clock    (ps2clock),
        .ps2data     (ps2data),
        .keyPressed  (keyPressed),
        .ifPressed   (ifPressed),
        .rawCode     (rawCode),
        .codeValid   (codeValid),
        .frameErr    (frameErr),
        .o_dbg_state (dbg_state)
    );

    // clock
    initial begin
        systemClock = 1'b0;
        forever #10 systemClock = ~systemClock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge systemClock);
    endtask

    task automatic model_reset();
        m_held = 4'b0;
        m_brk  = 1'b0;
        m_ext  = 1'b0;
        m_key  = 2'd0;
        m_raw  = 8'd0;
    endtask

    function automatic int lookup(input logic [7:0] b, input logic ext);
        logic [7:0] letters[4];
        logic [7:0] arrows[4];
        letters = '{8'h1C, 8'h1B, 8'h23, 8'h2B};
        arrows  = '{8'h6B, 8'h75, 8'h72, 8'h74};
        for (int k = 0; k < 4; k++) begin
`ifdef PS2_EXTENDED_EN
            if (ext && arrows[k] == b) return k;
            if (!ext && letters[k] == b) return k;
`else
            if (letters[k] == b) return k;
`endif
        end
        return -1;
    endfunction

    // Reference behaviour for a cleanly received byte.
    task automatic model_byte(input logic [7:0] b);
        exp_t e;
        int   idx;
        logic fire;
        fire = 1'b0;
        idx  = lookup(b, m_ext);
        if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (m_brk) begin
            m_brk = 1'b0;
            if (idx >= 0) m_held[idx] = 1'b0;
            m_ext = 1'b0;
`ifdef PS2_EXTENDED_EN
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
`endif
        end else begin
            m_ext = 1'b0;
            if (idx >= 0 && !m_held[idx]) begin
                m_held[idx] = 1'b1;
                m_key       = 2'(idx);
                fire        = 1'b1;
            end
        end
        m_raw  = b;
        e.code = b;
        e.key  = m_key;
        e.fire = fire;
        exp_q.push_back(e);
    endtask

    // Driver: clock out nbits of a frame (11 = complete) at a random PS/2 rate.
    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop,
                              input int nbits, input bit do_model);
        logic [10:0] bits;
        int          hp;
        exp_t        e;
        bits = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
        hp   = int'($urandom_range(4, 10));
        if (do_model) begin
            if (nbits < 11 || flip_par || bad_stop) begin
                e.code = m_raw;
                e.key  = m_key;
                e.fire = 1'b0;
                err_q.push_back(e);
            end else begin
                model_byte(b);
            end
        end
        for (int i = 0; i < nbits; i++) begin
            ps2data = bits[i];
            wait_clks(hp);
            ps2clock = 1'b0;
            wait_clks(hp);
            ps2clock = 1'b1;
        end
        wait_clks(hp);
        ps2data = 1'b1;
        wait_clks(12);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11, 1'b1);
    endtask

    // Monitor: every strobe must match the head of the matching expected queue.
    always @(negedge systemClock) begin
        exp_t e;
        if (reset) begin
            if (codeValid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_codeValid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rawCode", 32'(rawCode), 32'(e.code));
                    check("keyPressed", 32'(keyPressed), 32'(e.key));
                    check("ifPressed", 32'(ifPressed), 32'(e.fire));
                end
            end else if (ifPressed) begin
                check("ifPressed_without_codeValid", 1, 0);
            end
            if (frameErr) begin
                if (err_q.size() == 0) begin
                    check("unexpected_frameErr", 1, 0);
                end else begin
                    e = err_q.pop_front();
                    check("rawCode_after_err", 32'(rawCode), 32'(e.code));
                    check("keyPressed_after_err", 32'(keyPressed), 32'(e.key));
                end
            end
        end
    end

    // Time limit for the whole run.
    initial begin
        #(20 * 90000);
        $display("FAIL watchdog actual=running required=finished");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        logic [7:0] pool[10];
        logic [7:0] b;
        pool = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'hF0, 8'hE0, 8'h6B, 8'h75, 8'h72, 8'h74};
        ps2clock = 1'b1;
        ps2data  = 1'b1;
        reset    = 1'b0;
        model_reset();
        wait_clks(5);
        check("rst_keyPressed", 32'(keyPressed), 0);
        check("rst_ifPressed", 32'(ifPressed), 0);
        check("rst_rawCode", 32'(rawCode), 0);
        check("rst_codeValid", 32'(codeValid), 0);
        check("rst_frameErr", 32'(frameErr), 0);
        check("rst_state", 32'(dbg_state), 0);
        reset = 1'b1;
        wait_clks(5);

        // 1: reset in the middle of a frame, then a clean 1C
        send_frame(8'h1C, 1'b0, 1'b0, 5, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wait_clks(1);
            check("midreset_strobes", 32'({codeValid, ifPressed, frameErr}), 0);
        end
        check("midreset_state", 32'(dbg_state), 0);
        reset = 1'b1;
        model_reset();
        wait_clks(5);
        send(8'h1C);

        // 2: typematic repeats, release, press again
        send(8'h23); send(8'h23); send(8'h23);
        send(8'hF0); send(8'h23);
        send(8'h23);

        // 3: bad parity and bad stop bit
        send_frame(8'h2B, 1'b1, 1'b0, 11, 1'b1);
        send_frame(8'h2B, 1'b0, 1'b1, 11, 1'b1);

        // 4: truncated frame times out, then a clean 1B
        send_frame(8'h1B, 1'b0, 1'b0, 6, 1'b1);
        wait_clks(TMO + 100);
        check("timeout_state_idle", 32'(dbg_state), 0);
        check("timeout_err_consumed", 32'(err_q.size()), 0);
        send(8'h1B);

        // 5: release everything, then two keys overlapping
        send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h1B);
        send(8'hF0); send(8'h23);
        send(8'h1C); send(8'h1B);
        send(8'hF0); send(8'h1C); send(8'h1C);

        // 6: extended arrow sequence
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);

        // random traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 5) == 0) b = 8'($urandom_range(0, 255));
            else b = pool[$urandom_range(0, 9)];
            if ($urandom_range(0, 29) == 0) begin
                send_frame(b, 1'b0, 1'b0, int'($urandom_range(1, 10)), 1'b1);
                wait_clks(TMO + 50);
            end else begin
                send_frame(b, ($urandom_range(0, 11) == 0), ($urandom_range(0, 15) == 0), 11, 1'b1);
            end
        end

        wait_clks(50);
        check("exp_q_drained", 32'(exp_q.size()), 0);
        check("err_q_drained", 32'(err_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
